// File: rtl/load_store_multiple_sequencer_pkg.sv
// Shared definitions for the load/store-multiple sequencer.
// Holds the width constants, the addressing-mode and FSM state encodings,
// and the byte-enable pattern used for full-word stores.
package load_store_multiple_sequencer_pkg;

    localparam int ADDR_W     = 32;   // memory address and data width
    localparam int REG_ADDR_W = 4;    // register number width
    localparam int TAG_W      = 4;    // instruction tag width
    localparam int W_EN_W     = 4;    // byte write-enable width
    localparam int NUM_REGS   = 16;   // architectural registers

    // Addressing modes of the multiple transfer
    typedef enum logic [1:0] {
        MODE_IA = 2'b00,   // increment after
        MODE_IB = 2'b01,   // increment before
        MODE_DA = 2'b10,   // decrement after
        MODE_DB = 2'b11    // decrement before
    } lsm_mode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } lsm_state_e;

    // Byte enables for a full-word store beat
    localparam logic [W_EN_W-1:0] W_EN_WORD = 4'b1111;

endpackage

// File: rtl/load_store_multiple_sequencer_lowest_set_bit.sv
// Lowest-set-bit finder for the register list.
// Ports:
//   vec_in   - register mask, bit i = register i
//   idx_out  - index of the lowest set bit (0 when the mask is empty)
//   none_out - 1 when no bit of vec_in is set
module lsm_lowest_set_bit
    import load_store_multiple_sequencer_pkg::*;
(
    input  logic [NUM_REGS-1:0]   vec_in,
    output logic [REG_ADDR_W-1:0] idx_out,
    output logic                  none_out
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        idx_out  = '0;
        none_out = 1'b1;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (vec_in[i]) begin
                idx_out  = REG_ADDR_W'(i);
                none_out = 1'b0;
            end
        end
    end

endmodule

// File: rtl/load_store_multiple_sequencer.sv
// Load/store-multiple sequencer: initiator side of the memory stage.
// Takes one LDM/STM request and emits one word beat per accepted cycle,
// lowest register at the lowest address, then pulses done_out.
// Ports:
//   clk_in, reset_in (async, active-low)
//   start_in, reg_list_in, base_addr_in, rn_addr_in, mode_in, load_in,
//   writeback_in, instr_tag_in           - request from issue logic
//   stall_in                             - memory stage back-pressure
//   reg_rd_addr_out / reg_rd_data_in     - register file read for STM data
//   mem_addr_out, mem_w_en_out, store_data_out, rd_addr_out,
//   instr_tag_out, valid_out, multiple_en_out - current beat
//   rn_addr_out, rn_data_out, rn_wb_en_out    - base writeback (last beat)
//   busy_out, done_out                        - sequencer status
module load_store_multiple_sequencer
    import load_store_multiple_sequencer_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [NUM_REGS-1:0]   reg_list_in,
    input  logic [ADDR_W-1:0]     base_addr_in,
    input  logic [REG_ADDR_W-1:0] rn_addr_in,
    input  logic [1:0]            mode_in,
    input  logic                  load_in,
    input  logic                  writeback_in,
    input  logic [TAG_W-1:0]      instr_tag_in,
    input  logic                  stall_in,
    output logic [REG_ADDR_W-1:0] reg_rd_addr_out,
    input  logic [ADDR_W-1:0]     reg_rd_data_in,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [W_EN_W-1:0]     mem_w_en_out,
    output logic [ADDR_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [TAG_W-1:0]      instr_tag_out,
    output logic                  valid_out,
    output logic                  multiple_en_out,
    output logic [REG_ADDR_W-1:0] rn_addr_out,
    output logic [ADDR_W-1:0]     rn_data_out,
    output logic                  rn_wb_en_out,
    output logic                  busy_out,
    output logic                  done_out
);

    function automatic logic [4:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    lsm_state_e          state_q;
    logic [NUM_REGS-1:0] mask_q;        // registers not yet presented
    logic                load_q;
    logic [ADDR_W-1:0]   wb_value_q;
    logic                wb_en_q;

    // One finder serves both the start beat (raw list) and later beats (mask).
    logic [NUM_REGS-1:0]   lsb_vec;
    logic [REG_ADDR_W-1:0] lsb_idx;
    logic                  lsb_none;
    logic [NUM_REGS-1:0]   mask_d;
    logic                  last_d;

    assign lsb_vec = (state_q == ST_IDLE) ? reg_list_in : mask_q;

    lsm_lowest_set_bit u_lsb (
        .vec_in   (lsb_vec),
        .idx_out  (lsb_idx),
        .none_out (lsb_none)
    );

    // The register about to become a beat is read now so its data is
    // captured on the same edge that presents the beat.
    assign reg_rd_addr_out = lsb_idx;
    assign mask_d          = lsb_vec & ~(NUM_REGS'(1) << lsb_idx);
    assign last_d          = (mask_d == '0);

    logic [4:0]        n_regs;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_value;
    logic              wb_en_value;

    always_comb begin
        n_regs     = popcount(reg_list_in);
        span       = ADDR_W'({n_regs, 2'b00});
        start_addr = base_addr_in;
        wb_value   = base_addr_in + span;
        case (lsm_mode_e'(mode_in))
            MODE_IA: begin start_addr = base_addr_in;                wb_value = base_addr_in + span; end
            MODE_IB: begin start_addr = base_addr_in + 32'd4;        wb_value = base_addr_in + span; end
            MODE_DA: begin start_addr = base_addr_in - span + 32'd4; wb_value = base_addr_in - span; end
            MODE_DB: begin start_addr = base_addr_in - span;         wb_value = base_addr_in - span; end
            default: begin start_addr = base_addr_in;                wb_value = base_addr_in + span; end
        endcase
        start_addr[1:0] = 2'b00;
        // A load that overwrites the base register wins over writeback.
        wb_en_value = writeback_in & ~(load_in & reg_list_in[rn_addr_in]);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q         <= ST_IDLE;
            mask_q          <= '0;
            load_q          <= 1'b0;
            wb_value_q      <= '0;
            wb_en_q         <= 1'b0;
            mem_addr_out    <= '0;
            mem_w_en_out    <= '0;
            store_data_out  <= '0;
            rd_addr_out     <= '0;
            instr_tag_out   <= '0;
            valid_out       <= 1'b0;
            multiple_en_out <= 1'b0;
            rn_addr_out     <= '0;
            rn_data_out     <= '0;
            rn_wb_en_out    <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        busy_out      <= 1'b1;
                        instr_tag_out <= instr_tag_in;
                        rn_addr_out   <= rn_addr_in;
                        load_q        <= load_in;
                        wb_value_q    <= wb_value;
                        wb_en_q       <= wb_en_value;
                        if (lsb_none) begin
                            // Empty list: no beat, straight to completion.
                            mask_q   <= '0;
                            state_q  <= ST_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state_q         <= ST_XFER;
                            mask_q          <= mask_d;
                            valid_out       <= 1'b1;
                            mem_addr_out    <= start_addr;
                            mem_w_en_out    <= load_in ? '0 : W_EN_WORD;
                            store_data_out  <= load_in ? '0 : reg_rd_data_in;
                            rd_addr_out     <= lsb_idx;
                            multiple_en_out <= ~last_d;
                            rn_data_out     <= last_d ? wb_value : '0;
                            rn_wb_en_out    <= last_d & wb_en_value;
                        end
                    end
                end
                ST_XFER: begin
                    if (!stall_in) begin
                        if (mask_q != '0) begin
                            mask_q          <= mask_d;
                            mem_addr_out    <= mem_addr_out + 32'd4;
                            store_data_out  <= load_q ? '0 : reg_rd_data_in;
                            rd_addr_out     <= lsb_idx;
                            multiple_en_out <= ~last_d;
                            rn_data_out     <= last_d ? wb_value_q : '0;
                            rn_wb_en_out    <= last_d & wb_en_q;
                        end else begin
                            // Last beat accepted.
                            valid_out       <= 1'b0;
                            multiple_en_out <= 1'b0;
                            rn_data_out     <= '0;
                            rn_wb_en_out    <= 1'b0;
                            state_q         <= ST_DONE;
                            done_out        <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    mask_q   <= '0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_multiple_sequencer.sv
module tb_load_store_multiple_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [15:0] reg_list_in;
    logic [31:0] base_addr_in;
    logic [3:0]  rn_addr_in;
    logic [1:0]  mode_in;
    logic        load_in;
    logic        writeback_in;
    logic [3:0]  instr_tag_in;
    logic        stall_in;
    logic [3:0]  reg_rd_addr_out;
    logic [31:0] reg_rd_data_in;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_w_en_out;
    logic [31:0] store_data_out;
    logic [3:0]  rd_addr_out;
    logic [3:0]  instr_tag_out;
    logic        valid_out;
    logic        multiple_en_out;
    logic [3:0]  rn_addr_out;
    logic [31:0] rn_data_out;
    logic        rn_wb_en_out;
    logic        busy_out;
    logic        done_out;

    localparam logic [1:0] IA = 2'b00, IB = 2'b01, DA = 2'b10, DB = 2'b11;

    load_store_multiple_sequencer dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .reg_list_in     (reg_list_in),
        .base_addr_in    (base_addr_in),
        .rn_addr_in      (rn_addr_in),
        .mode_in         (mode_in),
        .load_in         (load_in),
        .writeback_in    (writeback_in),
        .instr_tag_in    (instr_tag_in),
        .stall_in        (stall_in),
        .reg_rd_addr_out (reg_rd_addr_out),
        .reg_rd_data_in  (reg_rd_data_in),
        .mem_addr_out    (mem_addr_out),
        .mem_w_en_out    (mem_w_en_out),
        .store_data_out  (store_data_out),
        .rd_addr_out     (rd_addr_out),
        .instr_tag_out   (instr_tag_out),
        .valid_out       (valid_out),
        .multiple_en_out (multiple_en_out),
        .rn_addr_out     (rn_addr_out),
        .rn_data_out     (rn_data_out),
        .rn_wb_en_out    (rn_wb_en_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Register file: register r holds 0xDA7A000r.
    assign reg_rd_data_in = {28'hDA7A000, reg_rd_addr_out};

    typedef struct packed {
        logic        is_done;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] data;
        logic [3:0]  rd;
        logic [3:0]  tag;
        logic        men;
        logic [3:0]  rn;
        logic [31:0] rn_data;
        logic        wb;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   done_cnt     = 0;
    logic [3:0] cur_tag;
    logic [3:0] cur_rn;

    task automatic push_beat(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                             input logic [3:0] r, input logic men, input logic [31:0] rnd,
                             input logic wb);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.wen = we; e.data = d; e.rd = r;
        e.tag = cur_tag; e.men = men; e.rn = cur_rn; e.rn_data = rnd; e.wb = wb;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every accepted beat and every done pulse.
    always @(negedge clk_in) begin
        if (reset_in === 1'b1) begin
            if (valid_out && !stall_in) begin
                exp_t got;
                exp_t e;
                got = {1'b0, mem_addr_out, mem_w_en_out, store_data_out, rd_addr_out,
                       instr_tag_out, multiple_en_out, rn_addr_out, rn_data_out, rn_wb_en_out};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_unexpected: got %h, required no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        tests_failed++;
                        $display("FAIL beat: got %h, required %h", got, e);
                    end else
                        $display("[TB] beat addr=%h rd=%0d data=%h men=%b rn_data=%h wb=%b ok",
                                 mem_addr_out, rd_addr_out, store_data_out, multiple_en_out,
                                 rn_data_out, rn_wb_en_out);
                end
            end
            if (done_out) begin
                exp_t e;
                done_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL done_unexpected: got done_out=1, required 0");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        tests_failed++;
                        $display("FAIL done_order: got done_out=1, required beat %h", e);
                    end else
                        $display("[TB] done pulse ok");
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else
            $display("[TB] %s ok (%h)", name, got);
    endtask

    task automatic start_req(input logic [15:0] list, input logic [31:0] base, input logic [1:0] mode,
                             input logic ld, input logic wb, input logic [3:0] tag, input logic [3:0] rn);
        @(posedge clk_in); #1;
        reg_list_in = list; base_addr_in = base; mode_in = mode; load_in = ld;
        writeback_in = wb; instr_tag_in = tag; rn_addr_in = rn; start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        for (c = 0; c < 40; c++) begin
            @(negedge clk_in); #2;
            if (exp_q.size() == 0 && !busy_out) break;
        end
        check({name, "_drain"}, {32'd0, exp_q.size(), busy_out}, 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] seq_tbl [4];
        int d0;
        reset_in = 1'b0; start_in = 1'b0; reg_list_in = '0; base_addr_in = '0;
        rn_addr_in = '0; mode_in = IA; load_in = 1'b0; writeback_in = 1'b0;
        instr_tag_in = '0; stall_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); #1;
        check("reset_outputs", {63'd0, |{mem_addr_out, mem_w_en_out, store_data_out, rd_addr_out,
              instr_tag_out, valid_out, multiple_en_out, rn_addr_out, rn_data_out, rn_wb_en_out,
              busy_out, done_out}}, 64'd0);
        @(posedge clk_in); #1;
        reset_in = 1'b1;

        // 1: STM IA, three beats, cycle-exact {valid, men, done}
        cur_tag = 4'h1; cur_rn = 4'hD;
        push_beat(32'h1000, 4'hF, 32'hDA7A0000, 4'd0, 1'b1, 32'h0, 1'b0);
        push_beat(32'h1004, 4'hF, 32'hDA7A0001, 4'd1, 1'b1, 32'h0, 1'b0);
        push_beat(32'h1008, 4'hF, 32'hDA7A0003, 4'd3, 1'b0, 32'h100C, 1'b0);
        push_done();
        seq_tbl[0] = 3'b110; seq_tbl[1] = 3'b110; seq_tbl[2] = 3'b100; seq_tbl[3] = 3'b001;
        start_req(16'h000B, 32'h1000, IA, 1'b0, 1'b0, 4'h1, 4'hD);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in); #1;
            check($sformatf("t1_timing_%0d", k), {61'd0, valid_out, multiple_en_out, done_out},
                  {61'd0, seq_tbl[k]});
        end
        drain("t1");

        // 2: LDM DB with writeback
        cur_tag = 4'h2; cur_rn = 4'h2;
        push_beat(32'h1FF8, 4'h0, 32'h0, 4'd0, 1'b1, 32'h0, 1'b0);
        push_beat(32'h1FFC, 4'h0, 32'h0, 4'd15, 1'b0, 32'h1FF8, 1'b1);
        push_done();
        start_req(16'h8001, 32'h2000, DB, 1'b1, 1'b1, 4'h2, 4'h2);
        drain("t2");

        // 3: STM IB single beat, stalled two cycles
        cur_tag = 4'h3; cur_rn = 4'h2;
        push_beat(32'h3004, 4'hF, 32'hDA7A0004, 4'd4, 1'b0, 32'h3004, 1'b1);
        push_done();
        start_req(16'h0010, 32'h3000, IB, 1'b0, 1'b1, 4'h3, 4'h2);
        stall_in = 1'b1;
        @(negedge clk_in); #1;
        check("t3_hold_0", {27'd0, valid_out, mem_addr_out, rd_addr_out}, {27'd0, 1'b1, 32'h3004, 4'd4});
        @(posedge clk_in); #1;
        @(negedge clk_in); #1;
        check("t3_hold_1", {27'd0, valid_out, mem_addr_out, rd_addr_out}, {27'd0, 1'b1, 32'h3004, 4'd4});
        @(posedge clk_in); #1;
        stall_in = 1'b0;
        @(negedge clk_in); #1;
        check("t3_hold_2", {27'd0, valid_out, mem_addr_out, rd_addr_out}, {27'd0, 1'b1, 32'h3004, 4'd4});
        d0 = done_cnt;
        drain("t3");
        check("t3_done_once", 64'(done_cnt - d0), 64'd1);

        // 4: empty list; a start in the DONE cycle is ignored
        cur_tag = 4'h4; cur_rn = 4'h0;
        push_done();
        start_req(16'h0000, 32'h0400, DA, 1'b0, 1'b1, 4'h4, 4'h0);
        start_in = 1'b1; reg_list_in = 16'h0001;
        @(negedge clk_in); #1;
        check("t4_done_cycle", {61'd0, valid_out, done_out, busy_out}, 64'b011);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(negedge clk_in); #1;
        check("t4_after", {61'd0, valid_out, done_out, busy_out}, 64'b000);
        drain("t4");

        // 5: address wrap
        cur_tag = 4'h5; cur_rn = 4'h5;
        push_beat(32'hFFFFFFFC, 4'h0, 32'h0, 4'd0, 1'b1, 32'h0, 1'b0);
        push_beat(32'h00000000, 4'h0, 32'h0, 4'd1, 1'b0, 32'h00000004, 1'b1);
        push_done();
        start_req(16'h0003, 32'hFFFFFFFC, IA, 1'b1, 1'b1, 4'h5, 4'h5);
        drain("t5");

        // 6: reset during beat 2 of a 4-beat LDM
        cur_tag = 4'h6; cur_rn = 4'h4;
        push_beat(32'h5000, 4'h0, 32'h0, 4'd4, 1'b1, 32'h0, 1'b0);
        push_beat(32'h5004, 4'h0, 32'h0, 4'd5, 1'b1, 32'h0, 1'b0);
        d0 = done_cnt;
        start_req(16'h00F0, 32'h5000, IA, 1'b1, 1'b1, 4'h6, 4'h4);
        @(posedge clk_in); #1;
        @(negedge clk_in); #1;
        reset_in = 1'b0;
        #1;
        check("t6_reset_outputs", {63'd0, |{mem_addr_out, mem_w_en_out, store_data_out, rd_addr_out,
              instr_tag_out, valid_out, multiple_en_out, rn_addr_out, rn_data_out, rn_wb_en_out,
              busy_out, done_out}}, 64'd0);
        @(posedge clk_in); @(posedge clk_in); #1;
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("t6_no_done", {32'd0, 32'(done_cnt - d0)}, {32'd0, 32'd0});
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // Rerun after reset; rn in list suppresses writeback; mid-XFER start ignored
        cur_tag = 4'h7; cur_rn = 4'h4;
        push_beat(32'h5000, 4'h0, 32'h0, 4'd4, 1'b1, 32'h0, 1'b0);
        push_beat(32'h5004, 4'h0, 32'h0, 4'd5, 1'b1, 32'h0, 1'b0);
        push_beat(32'h5008, 4'h0, 32'h0, 4'd6, 1'b1, 32'h0, 1'b0);
        push_beat(32'h500C, 4'h0, 32'h0, 4'd7, 1'b0, 32'h5010, 1'b0);
        push_done();
        start_req(16'h00F0, 32'h5000, IA, 1'b1, 1'b1, 4'h7, 4'h4);
        start_in = 1'b1; reg_list_in = 16'hFFFF; base_addr_in = 32'h0;
        instr_tag_in = 4'h9; rn_addr_in = 4'h1; load_in = 1'b0; mode_in = DB;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        drain("t6_rerun");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_multiple_sequencer.md
Name: load_store_multiple_sequencer

Overview:
Initiator side of the load/store memory stage interface. Accepts one LDM/STM request (register list, base, addressing mode) from the issue logic. Emits one word transfer per cycle: address, write enable, store data, destination register and tag, in the fields the memory stage consumes. It drives the multiple-enable flag on every beat but the last, and presents the base-writeback value on the final beat.

Parameters:
ADDR_W, 32, memory address and data width
REG_ADDR_W, 4, register address width (16 architectural registers)
TAG_W, 4, instruction tag width
W_EN_W, 4, byte write-enable width

Ports:
clk_in  in  1  clock, rising edge
reset_in  in  1  reset, asynchronous, active-low
start_in  in  1  request strobe; sampled only in IDLE
reg_list_in  in  16  register list; bit i selects register i
base_addr_in  in  32  base register (Rn) value
rn_addr_in  in  4  base register number
mode_in  in  2  00 IA, 01 IB, 10 DA, 11 DB
load_in  in  1  1 = LDM, 0 = STM
writeback_in  in  1  base writeback requested
instr_tag_in  in  4  tag of the multiple instruction
stall_in  in  1  memory stage cannot accept; hold current beat
reg_rd_addr_out  out  4  register file read address for STM data (combinational, = next register)
reg_rd_data_in  in  32  register file read data (same cycle)
mem_addr_out  out  32  word address of current beat, bits[1:0] = 0
mem_w_en_out  out  4  4'b1111 on STM beats, 4'b0000 on LDM beats
store_data_out  out  32  store data of current beat
rd_addr_out  out  4  register of current beat
instr_tag_out  out  4  latched tag
valid_out  out  1  beat valid (memory stage start bit)
multiple_en_out  out  1  1 on all beats except the last
rn_addr_out  out  4  latched base register number
rn_data_out  out  32  base writeback value, valid on last beat only
rn_wb_en_out  out  1  1 on last beat when writeback_in was set
busy_out  out  1  1 in XFER and DONE
done_out  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- All outputs are registered except reg_rd_addr_out. Reset values: all outputs 0, state IDLE, remaining mask 0. Reset mid-operation aborts the sequence with no done_out.
- States: IDLE, XFER, DONE.
- IDLE: on start_in=1, latch the request. n = popcount(reg_list_in).
- Start address: IA base; IB base+4; DA base-4n+4; DB base-4n.
- Writeback value: IA/IB base+4n; DA/DB base-4n.
- All arithmetic is mod 2^32; wrap is permitted and not flagged.
- Address bits[1:0] are forced to 0.
- n>0: load the first beat into the output registers, go to XFER. valid_out=1 in cycle T+1, where T is the start edge.
- n=0: go to DONE. No beat is issued. done_out=1 in cycle T+1. The writeback value equals base and is not driven.
- XFER, per cycle with stall_in=0:
  - Current beat is accepted.
  - Next beat = lowest remaining set bit; lowest register goes to the lowest address.
  - Address += 4; that bit is cleared from the mask.
  - store_data_out is captured from reg_rd_data_in for STM, and is 0 for LDM.
- stall_in=1: every output holds its value and the mask and address do not advance.
- Last beat:
  - multiple_en_out=0.
  - rn_data_out = writeback value.
  - rn_wb_en_out = writeback_in, except it is forced to 0 for LDM whose list contains rn.
  - When it is accepted, valid_out is 0 the next cycle and the state moves to DONE.
- DONE: done_out=1 for exactly one cycle, then IDLE. A start_in in that cycle is ignored.
- start_in while busy_out=1 is ignored. Latched fields do not change.
- Latency: n beats occupy cycles T+1..T+n+stalls. done_out is asserted one cycle later.

Decomposition:
- Shared package/define file:
  - mode encodings IA/IB/DA/DB
  - state encodings
  - ADDR_W, REG_ADDR_W, TAG_W, W_EN_W
  - word-store enable constant 4'b1111
- One sub-module, lsm_lowest_set_bit: 16-bit input; outputs a 4-bit index of the lowest set bit and a none flag. It is used for both the next register and the mask clear.
- Popcount is a small function in the sequencer.

Test Plan:
1. STM IA, base=0x1000, list=0x000B, no stall -> three beats: (0x1000,r0), (0x1004,r1), (0x1008,r3); w_en=F each; multiple_en 1,1,0; rn_data=0x100C on last beat; done_out the next cycle.
2. LDM DB, base=0x2000, list=0x8001, writeback=1 -> beats (0x1FF8,r0), (0x1FFC,r15); w_en=0; rn_data=0x1FF8; rn_wb_en=1 on the last beat.
3. STM IB, list=0x0010, base=0x3000, stall_in high for 2 cycles on the beat -> addr 0x3004 and rd r4 held stable for 3 cycles; single beat with multiple_en=0; done once.
4. Empty list, DA, base=0x400 -> no valid_out; done_out at T+1; busy_out high for one cycle.
5. Wrap: IA, base=0xFFFFFFFC, list=0x0003 -> addrs 0xFFFFFFFC, 0x00000000; rn_data=0x00000004.
6. reset_in low during beat 2 of a 4-beat LDM -> all outputs 0 immediately; no done_out; a new start after release runs normally. Also: start_in pulsed mid-XFER is ignored.
